// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit full adder cell with a registered carry for bit-serial addition.
module serial_bit_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  logic carry_q, carry_d;

  assign s = x ^ y ^ carry_q;
  assign c = (x & y) | (x & carry_q) | (y & carry_q);

  always_comb begin
    carry_d = clr ? 1'b0 : c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (ena) begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds LSB first,
// and presents sum/cout with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit added per enabled cycle
// DONE  | sum/cout newly valid, done asserted
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] acc_shift;
  logic             bit_s, bit_c;
  logic             load, step;

  assign load = ena && start && (state_q == IDLE || state_q == DONE);
  assign step = ena && (state_q == RUN);

  serial_bit_adder u_bit (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (load | step),
    .clr  (load),
    .x    (sha_q[0]),
    .y    (shb_q[0]),
    .s    (bit_s),
    .c    (bit_c)
  );

  // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
  if (WIDTH > 1) begin : g_acc_wide
    assign acc_shift = {bit_s, acc_q[WIDTH-1:1]};
  end else begin : g_acc_one
    assign acc_shift = bit_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (cnt_q == LAST) state_d = DONE;
        DONE:    state_d = start ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    sha_d  = sha_q;
    shb_d  = shb_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (load) begin
      sha_d = a;
      shb_d = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      sha_d = sha_q >> 1;
      shb_d = shb_q >> 1;
      acc_d = acc_shift;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        sum_d  = acc_shift;
        cout_d = bit_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sha_q  <= '0;
      shb_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sha_q  <= sha_d;
      shb_q  <= shb_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected results queued at issue,
// popped and compared by a monitor on each done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ena, start;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .start(start),
    .a    (a_i),
    .b    (b_i),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one comparison set per rising done.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    done_prev = done;
  end

  // Drive start for one edge; called at a negedge. extra = stalled edges to come.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int extra, input bit expect_done);
    logic [W:0] full;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a_i   = a;
    b_i   = b;
    full  = {1'b0, a} + {1'b0, b};
    if (expect_done) begin
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.due  = cyc + 1 + W + extra;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    start = 1'b1;
    a_i   = 8'hAA;
    b_i   = 8'h55;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    start = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b1;

    // 1: basic add, busy for W cycles
    start_op(8'h3C, 8'h5A, 0, 1'b1);
    for (int i = 0; i < W; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("no_done_run", 32'(done), 32'd0);
      @(negedge clk);
    end
    drain();

    // 2: overflow then zero
    start_op(8'hFF, 8'h01, 0, 1'b1);
    drain();
    start_op(8'h00, 8'h00, 0, 1'b1);
    drain();

    // 3: start re-pulsed mid-run is ignored
    start_op(8'h10, 8'h20, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a_i   = 8'h11;
    b_i   = 8'h22;
    @(negedge clk);
    start = 1'b0;
    drain();

    // 4: three-cycle stall mid-run
    start_op(8'h7F, 8'h01, 3, 1'b1);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_no_done", 32'(done), 32'd0);
    end
    ena = 1'b1;
    drain();

    // 4b: stall while in DONE holds done high
    start_op(8'hC3, 8'h4E, 0, 1'b1);
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 32'd1);
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_held", 32'(done), 32'd1);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("done_released", 32'(done), 32'd0);
    drain();

    // 5: reset at bit 4 abandons the run
    start_op(8'hA5, 8'h3C, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    repeat (W + 4) @(negedge clk);
    start_op(8'hE7, 8'h9C, 0, 1'b1);
    drain();

    // 6: start held high, back-to-back random operands
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] ra, rb;
      logic [W:0]   full;
      exp_t e;
      @(negedge clk);
      ra    = W'($urandom);
      rb    = W'($urandom);
      start = 1'b1;
      a_i   = ra;
      b_i   = rb;
      full  = {1'b0, ra} + {1'b0, rb};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.due  = cyc + 1 + W;
      q.push_back(e);
      repeat (W) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
